// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED blink/PWM pattern generator.
// A shared prescaler produces a tick every TICK_DIV run-high cycles; each
// channel steps a phase counter on that tick and drives its LED while the
// phase is below its on-time. Period/duty are shadowed at cycle boundaries.
// Optional macro LED_PATTERN_SYNC_RUN_EN: pass run through a 2-flop
// synchroniser (2 cycles of extra latency on every run transition).
module led_pattern_gen #(
    parameter int TICK_DIV = 600000,
    parameter int CHANNELS = 4,
    parameter int PHASE_W  = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          run,
    input  logic [CHANNELS*PHASE_W-1:0]   period,
    input  logic [CHANNELS*PHASE_W-1:0]   duty,
    output logic                          tick,
    output logic [CHANNELS-1:0]           leds
);

    // Smallest width that can hold TICK_DIV-1 (at least one bit).
    localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic             run_q;
    logic [PRE_W-1:0] pre;
    logic             adv;

`ifdef LED_PATTERN_SYNC_RUN_EN
    logic [1:0] run_sync;

    // Two-flop synchroniser for an asynchronous run source.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) run_sync <= 2'b00;
        else         run_sync <= {run_sync[0], run};
    end

    assign run_q = run_sync[1];
`else
    assign run_q = run;
`endif

    // Tick fires on the edge the prescaler wraps; phases advance on that edge too.
    assign adv = run_q && (pre == PRE_MAX);

    // Prescaler and registered tick pulse; everything holds while stopped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= adv;
            if (run_q) pre <= adv ? '0 : pre + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic [PHASE_W-1:0] phase;
        logic [PHASE_W-1:0] sh_per;
        logic [PHASE_W-1:0] sh_duty;
        logic [PHASE_W-1:0] per_in;
        logic [PHASE_W-1:0] duty_in;

        assign per_in  = period[i*PHASE_W +: PHASE_W];
        assign duty_in = duty[i*PHASE_W +: PHASE_W];

        // Shadows reload only at phase 0 so a config change never truncates a
        // cycle; phase wraps after reaching the shadowed period (period 0 pins it).
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                phase   <= '0;
                sh_per  <= '0;
                sh_duty <= '0;
                leds[i] <= 1'b0;
            end else begin
                if (phase == '0) begin
                    sh_per  <= per_in;
                    sh_duty <= duty_in;
                end
                if (adv) phase <= (phase == sh_per) ? '0 : phase + 1'b1;
                leds[i] <= (phase < sh_duty);
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: randomized + directed bench for led_pattern_gen
// (TICK_DIV=4, CHANNELS=2, PHASE_W=4). The reference model counts run-high
// cycles and ticks as integers; each channel's phase is "ticks since the
// start of its current cycle".
module tb_led_pattern_gen;

    localparam int TD = 4;
    localparam int CH = 2;
    localparam int PW = 4;
`ifdef LED_PATTERN_SYNC_RUN_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic              clk    = 1'b0;
    logic              resetn = 1'b0;
    logic              run    = 1'b0;
    logic [CH*PW-1:0]  period = '0;
    logic [CH*PW-1:0]  duty   = '0;
    logic              tick;
    logic [CH-1:0]     leds;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.TICK_DIV(TD), .CHANNELS(CH), .PHASE_W(PW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .run    (run),
        .period (period),
        .duty   (duty),
        .tick   (tick),
        .leds   (leds)
    );

    // ---------------- reference model ----------------
    int          runcnt;          // run-high edges since reset
    int          ticks;           // ticks since reset
    int          start [CH];      // tick count at which the channel's cycle began
    int          sp    [CH];
    int          sd    [CH];
    bit          s0, s1;          // run history for the synchronised build
    logic        m_tick;
    logic [CH-1:0] m_leds;

    task automatic model_reset();
        runcnt = 0; ticks = 0; s0 = 0; s1 = 0;
        m_tick = 1'b0; m_leds = '0;
        for (int c = 0; c < CH; c++) begin
            start[c] = 0; sp[c] = 0; sd[c] = 0;
        end
    endtask

    task automatic set_ch(input int c, input int p, input int d);
        period[c*PW +: PW] = PW'(p);
        duty[c*PW +: PW]   = PW'(d);
    endtask

    // One clock: update the model with the inputs seen at the edge, then
    // return at the falling edge where outputs are sampled.
    task automatic step();
        bit r_eff, tk;
        int ph;
        @(posedge clk);
        if (!resetn) model_reset();
        else begin
`ifdef LED_PATTERN_SYNC_RUN_EN
            r_eff = s1; s1 = s0; s0 = run;
`else
            r_eff = run;
`endif
            tk = r_eff && ((runcnt % TD) == TD - 1);
            if (r_eff) runcnt++;
            for (int c = 0; c < CH; c++) begin
                ph = ticks - start[c];
                m_leds[c] = (ph < sd[c]);
                if (tk && ph == sp[c]) start[c] = ticks + 1;
                if (ph == 0) begin
                    sp[c] = int'(period[c*PW +: PW]);
                    sd[c] = int'(duty[c*PW +: PW]);
                end
            end
            if (tk) ticks++;
            m_tick = tk;
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (tick !== 1'b0) begin
                failures++; $display("FAIL reset_tick got=%b exp=0", tick);
            end
            checks++;
            if (leds !== '0) begin
                failures++; $display("FAIL reset_leds got=%b exp=00", leds);
            end
        end
    endtask

    task automatic test_pattern();
        int nt = 0;
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (tick === 1'b1) nt++;
            checks++;
            if (tick !== m_tick) begin
                failures++; $display("FAIL pattern_tick cyc=%0d got=%b exp=%b", k, tick, m_tick);
            end
            checks++;
            if (leds !== m_leds) begin
                failures++; $display("FAIL pattern_leds cyc=%0d got=%b exp=%b", k, leds, m_leds);
            end
        end
        checks++;
        if (nt != (40 - SYNC_LAT) / TD) begin
            failures++; $display("FAIL pattern_tick_count got=%0d exp=%0d", nt, (40 - SYNC_LAT) / TD);
        end
    endtask

    task automatic test_zero_period();
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (leds[1] !== 1'b1) begin
                failures++; $display("FAIL zero_period_on cyc=%0d got=%b exp=1", k, leds[1]);
            end
        end
        set_ch(1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (leds !== m_leds) begin
                failures++; $display("FAIL zero_period_leds cyc=%0d got=%b exp=%b", k, leds, m_leds);
            end
            if (k >= 2) begin
                checks++;
                if (leds[1] !== 1'b0) begin
                    failures++; $display("FAIL zero_period_off cyc=%0d got=%b exp=0", k, leds[1]);
                end
            end
        end
    endtask

    task automatic test_reconfig();
        int guard = 0;
        while ((ticks - start[0]) != 2 && guard < 64) begin step(); guard++; end
        if (guard >= 64) begin
            checks++; failures++; $display("FAIL reconfig_wait got=timeout exp=phase2");
        end
        set_ch(0, 7, 5);
        for (int k = 0; k < 80; k++) begin
            step();
            checks++;
            if (tick !== m_tick || leds !== m_leds) begin
                failures++;
                $display("FAIL reconfig cyc=%0d got=%b/%b exp=%b/%b", k, tick, leds, m_tick, m_leds);
            end
        end
    endtask

    task automatic test_run_pause();
        int guard = 0;
        int first = 0;
        while (((runcnt + SYNC_LAT) % TD) != 2 && guard < 8) begin step(); guard++; end
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (tick !== 1'b0) begin
                failures++; $display("FAIL pause_tick cyc=%0d got=%b exp=0", k, tick);
            end
            checks++;
            if (leds !== m_leds) begin
                failures++; $display("FAIL pause_leds cyc=%0d got=%b exp=%b", k, leds, m_leds);
            end
        end
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (tick === 1'b1 && first == 0) first = k;
            checks++;
            if (tick !== m_tick || leds !== m_leds) begin
                failures++;
                $display("FAIL resume cyc=%0d got=%b/%b exp=%b/%b", k, tick, leds, m_tick, m_leds);
            end
        end
        checks++;
        if (first != 2 + SYNC_LAT) begin
            failures++; $display("FAIL resume_latency got=%0d exp=%0d", first, 2 + SYNC_LAT);
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        int first = 0;
        while (m_leds[0] !== 1'b1 && guard < 64) begin step(); guard++; end
        checks++;
        if (leds[0] !== 1'b1) begin
            failures++; $display("FAIL areset_pre got=%b exp=1", leds[0]);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (leds !== '0 || tick !== 1'b0) begin
            failures++; $display("FAIL areset_immediate got=%b/%b exp=0/00", tick, leds);
        end
        model_reset();
        step();
        resetn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tick === 1'b1 && first == 0) first = k;
            checks++;
            if (tick !== m_tick || leds !== m_leds) begin
                failures++;
                $display("FAIL areset_restart cyc=%0d got=%b/%b exp=%b/%b", k, tick, leds, m_tick, m_leds);
            end
        end
        checks++;
        if (first != TD + SYNC_LAT) begin
            failures++; $display("FAIL areset_first_tick got=%0d exp=%0d", first, TD + SYNC_LAT);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0)
                set_ch($urandom_range(0, CH - 1), $urandom_range(0, 15), $urandom_range(0, 15));
            resetn = ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if (tick !== m_tick || leds !== m_leds) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b/%b exp=%b/%b", k, tick, leds, m_tick, m_leds);
            end
        end
        resetn = 1'b1;
    endtask

    initial begin
        set_ch(0, 3, 2);
        set_ch(1, 0, 1);
        run    = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        test_reset();
        test_pattern();
        test_zero_period();
        test_reconfig();
        test_run_pause();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
